// File: rtl/spi_reg_frame_ctrl.sv
// SPI mode-0 slave front end sampled in the clk domain; decodes 2-byte
// command/data frames into single-cycle register write/read strobes.
module spi_reg_frame_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] STATUS_BYTE = 8'h5A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    input  logic       reg_rvalid,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] prime_sr;

    logic       sclk_p0, cs_n_p0, mosi_p0;
    logic       sclk_p1, cs_n_p1;
    logic       sck_rise, sck_fall, cs_fall, cs_rise;
    logic       primed, armed;

    logic [2:0] state;
    logic [3:0] bit_cnt;
    logic       is_write;
    logic       rd_got;
    logic [7:0] cmd, rx, tx_shift, rd_buf;
    logic [7:0] cmd_next, rx_next;

    // Input synchronizers (stage p0 = last synchronizer flop, p1 = previous value)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_n_sync <= '1;
            mosi_sync <= '0;
            prime_sr  <= '0;
            sclk_p1   <= 1'b0;
            cs_n_p1   <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            prime_sr  <= {prime_sr[SYNC_STAGES-2:0], 1'b1};
            sclk_p1   <= sclk_p0;
            cs_n_p1   <= cs_n_p0;
            // The cs_n=1 reset preload is not a real sample; arm only once the chain has flushed.
            armed     <= primed & cs_n_p0;
        end
    end

    assign sclk_p0  = sclk_sync[SYNC_STAGES-1];
    assign cs_n_p0  = cs_n_sync[SYNC_STAGES-1];
    assign mosi_p0  = mosi_sync[SYNC_STAGES-1];
    assign primed   = prime_sr[SYNC_STAGES-1];
    assign sck_rise = sclk_p0 & ~sclk_p1;
    assign sck_fall = ~sclk_p0 & sclk_p1;
    assign cs_fall  = ~cs_n_p0 & cs_n_p1;
    assign cs_rise  = cs_n_p0 & ~cs_n_p1;
    assign cmd_next = {cmd[6:0], mosi_p0};
    assign rx_next  = {rx[6:0], mosi_p0};

    // Frame control FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            is_write  <= 1'b0;
            rd_got    <= 1'b0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
            reg_addr  <= 7'd0;
            reg_wdata <= 8'd0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            frame_err <= 1'b0;
            // CS rising wins over any simultaneous SCK event.
            if (cs_rise && state != S_IDLE) begin
                state <= S_IDLE;
                if (state != S_DONE)
                    frame_err <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall && armed) begin
                            state   <= S_CMD;
                            bit_cnt <= 4'd0;
                            rd_got  <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                is_write <= cmd_next[7];
                                if (cmd_next[7]) begin
                                    state <= S_DATA;
                                end else begin
                                    state    <= S_RD_WAIT;
                                    reg_re   <= 1'b1;
                                    reg_addr <= cmd_next[6:0];
                                end
                            end
                        end
                    end
                    S_RD_WAIT: begin
                        if (reg_rvalid && !rd_got)
                            rd_got <= 1'b1;
                        if (sck_fall) begin
                            state <= S_DATA;
                            if (!rd_got)
                                frame_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                state <= S_DONE;
                                if (is_write) begin
                                    reg_we    <= 1'b1;
                                    reg_addr  <= cmd[6:0];
                                    reg_wdata <= rx_next;
                                end
                            end
                        end
                    end
                    S_DONE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Shift datapath; state gating keeps unreset contents from reaching outputs
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (cs_fall && armed)
                    tx_shift <= STATUS_BYTE;
            end
            S_CMD: begin
                if (sck_rise)
                    cmd <= cmd_next;
                if (sck_fall)
                    tx_shift <= {tx_shift[6:0], 1'b0};
            end
            S_RD_WAIT: begin
                if (reg_rvalid && !rd_got)
                    rd_buf <= reg_rdata;
                if (sck_fall)
                    tx_shift <= rd_got ? rd_buf : 8'hFF;
            end
            S_DATA: begin
                if (sck_rise)
                    rx <= rx_next;
                if (sck_fall && !is_write)
                    tx_shift <= {tx_shift[6:0], 1'b0};
            end
            default: ;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign spi_miso = ~cs_n_p0 & tx_shift[7] &
                      ((state == S_CMD) || (state == S_RD_WAIT) ||
                       ((state == S_DATA) && !is_write));

endmodule

// File: tb/tb_spi_reg_frame_ctrl.sv
// Directed bench for spi_reg_frame_ctrl: bit-banged SPI frames against a
// tiny register-file responder with hand-computed expectations.
module tb_spi_reg_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_rvalid = 1'b0;
    logic       busy;
    logic       frame_err;

    logic       model_en = 1'b1;
    logic [7:0] model_data = 8'hC3;
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         err_cnt = 0;
    logic [6:0] re_addr = 7'h00;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    spi_reg_frame_ctrl #(.SYNC_STAGES(2), .STATUS_BYTE(8'h5A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_miso  (spi_miso),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .reg_rvalid(reg_rvalid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Register-file responder and strobe counters
    always @(posedge clk) begin
        reg_rvalid <= 1'b0;
        if (reg_re && model_en) begin
            reg_rvalid <= 1'b1;
            reg_rdata  <= model_data;
        end
        if (reg_re) begin
            re_cnt  <= re_cnt + 1;
            re_addr <= reg_addr;
        end
        if (reg_we)
            we_cnt <= we_cnt + 1;
        if (frame_err)
            err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] d, input int n, output logic [7:0] m);
        m = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = d[i];
            wait_clk(8);
            m[i] = spi_miso;
            spi_sclk = 1'b1;
            wait_clk(8);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic frame_end();
        wait_clk(8);
        spi_cs_n = 1'b1;
        wait_clk(16);
    endtask

    initial begin
        logic [7:0] m0, m1, m2;
        int w0, r0, e0;

        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        wait_clk(4);
        chk("rst_busy", busy, 0);
        chk("rst_miso", spi_miso, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_strobes", {reg_we, reg_re, frame_err}, 0);
        rst_n = 1'b1;
        wait_clk(8);

        // Write 0x85 / 0x3C
        w0 = we_cnt; r0 = re_cnt; e0 = err_cnt;
        frame_start();
        xfer_bits(8'h85, 8, m0);
        xfer_bits(8'h3C, 8, m1);
        chk("wr_busy_mid", busy, 1);
        frame_end();
        chk("wr_we_cnt", we_cnt - w0, 1);
        chk("wr_addr", reg_addr, 7'h05);
        chk("wr_wdata", reg_wdata, 8'h3C);
        chk("wr_miso0", m0, 8'h5A);
        chk("wr_miso1", m1, 8'h00);
        chk("wr_busy_end", busy, 0);
        chk("wr_err", err_cnt - e0, 0);
        chk("wr_re", re_cnt - r0, 0);

        // Read 0x12, responder returns 0xC3
        w0 = we_cnt; r0 = re_cnt; e0 = err_cnt;
        model_en = 1'b1; model_data = 8'hC3;
        frame_start();
        xfer_bits(8'h12, 8, m0);
        xfer_bits(8'h00, 8, m1);
        frame_end();
        chk("rd_re_cnt", re_cnt - r0, 1);
        chk("rd_re_addr", re_addr, 7'h12);
        chk("rd_miso0", m0, 8'h5A);
        chk("rd_miso1", m1, 8'hC3);
        chk("rd_we_cnt", we_cnt - w0, 0);
        chk("rd_err", err_cnt - e0, 0);

        // Read with no response
        w0 = we_cnt; r0 = re_cnt; e0 = err_cnt;
        model_en = 1'b0;
        frame_start();
        xfer_bits(8'h34, 8, m0);
        xfer_bits(8'h00, 8, m1);
        frame_end();
        chk("late_miso1", m1, 8'hFF);
        chk("late_err", err_cnt - e0, 1);
        chk("late_re_cnt", re_cnt - r0, 1);
        chk("late_busy", busy, 0);
        model_en = 1'b1;
        w0 = we_cnt;
        frame_start();
        xfer_bits(8'h8A, 8, m0);
        xfer_bits(8'h5F, 8, m1);
        frame_end();
        chk("late_next_we", we_cnt - w0, 1);
        chk("late_next_addr", reg_addr, 7'h0A);
        chk("late_next_wdata", reg_wdata, 8'h5F);

        // Abort after 12 rises
        w0 = we_cnt; e0 = err_cnt;
        frame_start();
        xfer_bits(8'h85, 8, m0);
        xfer_bits(8'h3C, 4, m1);
        spi_cs_n = 1'b1;
        wait_clk(16);
        chk("abort_we", we_cnt - w0, 0);
        chk("abort_err", err_cnt - e0, 1);
        chk("abort_busy", busy, 0);
        w0 = we_cnt;
        frame_start();
        xfer_bits(8'h81, 8, m0);
        xfer_bits(8'h7E, 8, m1);
        frame_end();
        chk("abort_next_we", we_cnt - w0, 1);
        chk("abort_next_addr", reg_addr, 7'h01);
        chk("abort_next_wdata", reg_wdata, 8'h7E);

        // Reset mid-frame with CS held low
        w0 = we_cnt; r0 = re_cnt; e0 = err_cnt;
        frame_start();
        xfer_bits(8'h85, 5, m0);
        rst_n = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        xfer_bits(8'h85, 8, m0);
        xfer_bits(8'h3C, 8, m1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_miso0", m0, 8'h00);
        chk("rstmid_miso1", m1, 8'h00);
        chk("rstmid_addr", reg_addr, 7'h00);
        chk("rstmid_wdata", reg_wdata, 8'h00);
        chk("rstmid_strobes", (we_cnt - w0) + (re_cnt - r0) + (err_cnt - e0), 0);
        frame_end();
        w0 = we_cnt;
        frame_start();
        xfer_bits(8'h83, 8, m0);
        xfer_bits(8'h11, 8, m1);
        frame_end();
        chk("rstmid_next_we", we_cnt - w0, 1);
        chk("rstmid_next_addr", reg_addr, 7'h03);
        chk("rstmid_next_wdata", reg_wdata, 8'h11);

        // Overlength write frame
        w0 = we_cnt; e0 = err_cnt;
        frame_start();
        xfer_bits(8'h90, 8, m0);
        xfer_bits(8'hA5, 8, m1);
        xfer_bits(8'hFF, 8, m2);
        frame_end();
        chk("over_we", we_cnt - w0, 1);
        chk("over_addr", reg_addr, 7'h10);
        chk("over_wdata", reg_wdata, 8'hA5);
        chk("over_miso0", m0, 8'h5A);
        chk("over_miso2", m2, 8'h00);
        chk("over_err", err_cnt - e0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_reg_frame_ctrl.md
Name: spi_reg_frame_ctrl

Overview:
- System-clock SPI mode-0 slave front end and register-access sequencer.
- Oversamples SCK, CS_n and MOSI into the clk domain and decodes each frame as a 2-byte transaction: command byte, then data byte.
- Issues single-cycle write or read strobes to the register file, and returns read data on MISO during the second byte.
- Replaces SCK-clocked echo logic wherever a byte must be acted on inside the system clock domain.

Parameters:
- SYNC_STAGES, 2, synchronizer depth applied equally to spi_sclk, spi_cs_n and spi_mosi; minimum 2.
- STATUS_BYTE, 8'h5A, constant shifted out on MISO during the command byte.

Ports:
- clk  in  1  system clock; must run at ≥8× SCK frequency.
- rst_n  in  1  synchronous active-low reset.
- spi_sclk  in  1  SPI clock (CPOL=0), asynchronous to clk.
- spi_mosi  in  1  SPI data in, MSB first.
- spi_cs_n  in  1  chip select, active-low.
- spi_miso  out  1  SPI data out, MSB first.
- reg_addr  out  7  register address, i.e. cmd[6:0].
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read request.
- reg_rdata  in  8  read data; valid when reg_rvalid=1.
- reg_rvalid  in  1  read data valid, single-cycle.
- busy  out  1  high whenever state≠IDLE.
- frame_err  out  1  one-cycle error pulse.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low (rst_n).
- Reset values:
  - All outputs are 0 and state is IDLE.
  - Synchronizers reset to sclk=0, cs_n=1, mosi=0.
  - The armed flag is 0.
- Edge detection:
  - sck_rise/sck_fall/cs_fall/cs_rise are derived from the last synchronized value versus the registered previous value.
  - MOSI is taken from the same synchronizer depth, so it is aligned with sck_rise.
- armed: set while synchronized cs_n=1. A frame starts only on cs_fall with armed=1. This means that after reset with CS held low, no frame starts until CS has gone high and then low again.
- States: IDLE, CMD, RD_WAIT, DATA, DONE.
- IDLE:
  - cs_fall & armed → CMD, with bit_cnt=0 and tx_shift=STATUS_BYTE.
  - spi_miso=STATUS_BYTE[7] from the next cycle.
- CMD:
  - Each sck_rise shifts the sampled MOSI into cmd and increments bit_cnt.
  - Each sck_fall shifts tx_shift left.
  - On the 8th rise:
    - cmd[7]=1 (write) → DATA.
    - cmd[7]=0 (read) → reg_re=1 and reg_addr=cmd[6:0] on the next cycle (one cycle only), then RD_WAIT.
- RD_WAIT:
  - reg_rvalid captures reg_rdata into rd_buf.
  - On the 8th sck_fall:
    - If captured: tx_shift=rd_buf, spi_miso=rd_buf[7].
    - Otherwise: tx_shift=8'hFF, frame_err pulses once, and any later reg_rvalid in this frame is ignored.
  - Then → DATA.
- DATA:
  - Read: tx_shift shifts on sck_fall.
  - Write: spi_miso=0.
  - The 16th rise is followed by:
    - Write: on the next cycle, reg_we=1 with reg_addr=cmd[6:0] and reg_wdata=received byte, one cycle only.
    - Read: no strobe.
  - Then → DONE.
- DONE: SCK edges are ignored and spi_miso=0. cs_rise → IDLE.
- Abort: cs_rise in CMD, RD_WAIT or DATA →
  - IDLE.
  - No reg_we.
  - A pending read result is discarded.
  - frame_err pulses once.
  - A reg_re already issued is not retracted.
- spi_miso=0 whenever the synchronized cs_n=1, and in IDLE/DONE.
- Simultaneous events: cs_rise in the same cycle as the 16th sck_rise counts as an abort; the cs_rise takes priority.
- reg_addr and reg_wdata hold their last values between strobes.
- Reset mid-frame: immediate IDLE, no strobes issued, armed=0.

Test Plan:
1. Write: CS low, MOSI 0x85 then 0x3C, CS high.
   → exactly one reg_we, reg_addr=0x05, reg_wdata=0x3C.
   → MISO bytes 0x5A, 0x00.
   → busy=0 after cs_rise.
2. Read: MOSI 0x12 then 0x00; the model returns 0xC3 with reg_rvalid one cycle after reg_re.
   → one reg_re with reg_addr=0x12.
   → MISO bytes 0x5A, 0xC3.
   → no reg_we.
3. Late read: the model never asserts reg_rvalid.
   → MISO second byte 0xFF.
   → exactly one frame_err pulse.
   → IDLE after cs_rise, and the next write frame succeeds.
4. Abort: write frame 0x85/0x3C with CS raised after 12 SCK rises.
   → no reg_we, one frame_err pulse, busy=0.
   → the following 0x81/0x7E frame writes addr 0x01 with data 0x7E.
5. Reset mid-frame: assert rst_n=0 after 5 bits, keep CS low through release, clock 16 more SCKs.
   → all outputs 0, no strobes.
   → a new frame only after CS goes high then low.
6. Overlength: write frame 0x90/0xA5 followed by 8 extra SCK clocks.
   → exactly one reg_we with reg_addr=0x10 and reg_wdata=0xA5.
   → MISO=0 for bits 17–24.
